// File: rtl/interp_timing_ctrl_if.sv
// Interface bundle for interp_timing_ctrl.
//   enable        : run request, low forces IDLE
//   sample_valid  : one-cycle pulse per input sample
//   w_valid/w_in  : loop-filter NCO step (Q2.14) and its valid
//   uk            : fractional interval for the interpolator (Q2.14)
//   interp_strobe : interpolant due; ontime_strobe/mid_strobe tag it
//   locked/state  : FSM status (IDLE=0, ACQ=1, TRACK=2)
// master drives the inputs of the controller, slave is the controller itself.
interface interp_timing_if #(
    parameter int DW = 16
);
    logic                 enable;
    logic                 sample_valid;
    logic                 w_valid;
    logic signed [DW-1:0] w_in;
    logic signed [DW-1:0] uk;
    logic                 interp_strobe;
    logic                 ontime_strobe;
    logic                 mid_strobe;
    logic                 locked;
    logic [1:0]           state;

    modport master (
        output enable, sample_valid, w_valid, w_in,
        input  uk, interp_strobe, ontime_strobe, mid_strobe, locked, state
    );

    modport slave (
        input  enable, sample_valid, w_valid, w_in,
        output uk, interp_strobe, ontime_strobe, mid_strobe, locked, state
    );
endinterface

// File: rtl/interp_timing_ctrl.sv
// Timing-recovery NCO controller for a Farrow-style interpolator.
// A decrementing phase accumulator (eta) steps down by the NCO step on every
// input sample; each wrap below zero schedules one interpolant at fractional
// interval uk. Strobes alternate on-time / midpoint. The FSM spends
// ACQ_STROBES strobes at the nominal step, then tracks the clamped
// loop-filter step.
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : interp_timing_if.slave (see interface file for signal list)
module interp_timing_ctrl #(
    parameter int SYM_WIDTH   = 1,
    parameter int INT_WIDTH   = 1,
    parameter int DEC_WIDTH   = 14,
    parameter int W_NOM       = 8192,
    parameter int W_MIN       = 7373,
    parameter int W_MAX       = 9011,
    parameter int ACQ_STROBES = 64
) (
    input  logic            clk,
    input  logic            rstn,
    interp_timing_if.slave  bus
);
    localparam int DW = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
    localparam int EW = DEC_WIDTH + 2;
    localparam int CW = $clog2(ACQ_STROBES + 1);

    localparam logic [DEC_WIDTH-1:0]  ETA_MAX  = {DEC_WIDTH{1'b1}};
    localparam logic [EW-1:0]         ETA_WRAP = {2'b01, {DEC_WIDTH{1'b0}}};
    localparam logic [CW-1:0]         CNT_MAX  = CW'(ACQ_STROBES);
    localparam logic signed [DW-1:0]  W_NOM_C  = DW'(W_NOM);
    localparam logic signed [DW-1:0]  W_MIN_C  = DW'(W_MIN);
    localparam logic signed [DW-1:0]  W_MAX_C  = DW'(W_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // Limit the loop-filter step to the allowed NCO range.
    function automatic logic signed [DW-1:0] clamp_w(input logic signed [DW-1:0] w);
        logic signed [DW-1:0] r;
        if (w < W_MIN_C) begin
            r = W_MIN_C;
        end else if (w > W_MAX_C) begin
            r = W_MAX_C;
        end else begin
            r = w;
        end
        return r;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   locked_r;
    logic [DEC_WIDTH-1:0]   eta_r;
    logic signed [DW-1:0]   w_lat_r;
    logic [CW-1:0]          cnt_r;
    logic                   phase_r;
    logic [DEC_WIDTH-1:0]   uk_r;
    logic                   strobe_r;
    logic                   ontime_r;
    logic                   mid_r;

    logic                   nco_active_s;
    logic signed [EW-1:0]   w_eff_s;
    logic signed [EW-1:0]   diff_s;
    logic [EW-1:0]          diff_wrap_s;
    logic                   underflow_s;
    logic [DEC_WIDTH-1:0]   eta_next_s;
    logic [DEC_WIDTH:0]     eta_dbl_s;
    logic [DEC_WIDTH-1:0]   uk_next_s;

    // Next-state logic; a low enable wins over every other transition.
    always_comb begin
        state_next_s = state_r;
        if (!bus.enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = ST_ACQ;
                ST_ACQ: begin
                    if (cnt_r == CNT_MAX) begin
                        state_next_s = ST_TRACK;
                    end else begin
                        state_next_s = ST_ACQ;
                    end
                end
                ST_TRACK: state_next_s = ST_TRACK;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // NCO datapath: decrement, detect wrap, and derive the fractional interval.
    always_comb begin
        nco_active_s = bus.enable && bus.sample_valid &&
                       ((state_r == ST_ACQ) || (state_r == ST_TRACK));
        if (state_r == ST_TRACK) begin
            w_eff_s = EW'(w_lat_r);
        end else begin
            w_eff_s = EW'(W_NOM_C);
        end
        diff_s      = $signed({2'b00, eta_r}) - w_eff_s;
        underflow_s = diff_s[EW-1];
        if (underflow_s) begin
            diff_wrap_s = diff_s + ETA_WRAP;
        end else begin
            diff_wrap_s = diff_s;
        end
        eta_next_s = diff_wrap_s[DEC_WIDTH-1:0];
        // uk = 2*eta_old, saturated just below 1.0
        eta_dbl_s = {eta_r, 1'b0};
        if (eta_dbl_s > {1'b0, ETA_MAX}) begin
            uk_next_s = ETA_MAX;
        end else begin
            uk_next_s = eta_dbl_s[DEC_WIDTH-1:0];
        end
    end

    // State register and the registered lock flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            locked_r <= (state_next_s == ST_TRACK);
        end
    end

    // Accumulator, strobe counter, phase and strobe outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eta_r    <= ETA_MAX;
            cnt_r    <= {CW{1'b0}};
            phase_r  <= 1'b0;
            uk_r     <= {DEC_WIDTH{1'b0}};
            strobe_r <= 1'b0;
            ontime_r <= 1'b0;
            mid_r    <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            ontime_r <= 1'b0;
            mid_r    <= 1'b0;
            if (state_next_s == ST_IDLE) begin
                // Re-arm so the next acquisition starts from a full interval.
                eta_r   <= ETA_MAX;
                cnt_r   <= {CW{1'b0}};
                phase_r <= 1'b0;
            end else if (nco_active_s) begin
                eta_r <= eta_next_s;
                if (underflow_s) begin
                    strobe_r <= 1'b1;
                    ontime_r <= ~phase_r;
                    mid_r    <= phase_r;
                    phase_r  <= ~phase_r;
                    uk_r     <= uk_next_s;
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
            end
        end
    end

    // Latched loop-filter step; a same-cycle sample still sees the old value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_lat_r <= W_NOM_C;
        end else if (bus.w_valid) begin
            w_lat_r <= clamp_w(bus.w_in);
        end
    end

    assign bus.uk            = {{(DW-DEC_WIDTH){1'b0}}, uk_r};
    assign bus.interp_strobe = strobe_r;
    assign bus.ontime_strobe = ontime_r;
    assign bus.mid_strobe    = mid_r;
    assign bus.locked        = locked_r;
    assign bus.state         = state_r;
endmodule

// File: tb/tb_interp_timing_ctrl.sv
// Self-checking bench for interp_timing_ctrl with a reference model feeding
// a queue of expected outputs, one entry per clock.
module tb_interp_timing_ctrl;
    logic clk;
    logic rstn;

    interp_timing_if #(.DW(16)) bus ();

    interp_timing_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [15:0] uk;
        logic        strobe;
        logic        ontime;
        logic        mid;
        logic        locked;
        logic [1:0]  state;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec     = 0;
    int   n_miscmp  = 0;
    int   strobes_seen = 0;

    // reference model state
    int m_state, m_eta, m_wlat, m_cnt, m_phase, m_uk;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t sample_obs();
        obs_t o;
        o.uk     = bus.uk;
        o.strobe = bus.interp_strobe;
        o.ontime = bus.ontime_strobe;
        o.mid    = bus.mid_strobe;
        o.locked = bus.locked;
        o.state  = bus.state;
        return o;
    endfunction

    task automatic model_reset();
        m_state = 0; m_eta = 16383; m_wlat = 8192;
        m_cnt = 0; m_phase = 0; m_uk = 0;
        exp_q.delete();
    endtask

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic drive(input logic en, input logic sv, input logic wv, input int win);
        obs_t e;
        int d, weff, cnt_old;
        bus.enable = en; bus.sample_valid = sv; bus.w_valid = wv; bus.w_in = 16'(win);
        cnt_old = m_cnt;
        e.strobe = 1'b0; e.ontime = 1'b0; e.mid = 1'b0;
        if (!en) begin
            m_state = 0; m_eta = 16383; m_cnt = 0; m_phase = 0;
        end else begin
            if (sv && m_state != 0) begin
                weff = (m_state == 2) ? m_wlat : 8192;
                d = m_eta - weff;
                if (d < 0) begin
                    e.strobe = 1'b1;
                    e.ontime = (m_phase == 0);
                    e.mid    = (m_phase == 1);
                    m_uk     = (2 * m_eta > 16383) ? 16383 : 2 * m_eta;
                    m_phase  = 1 - m_phase;
                    if (m_cnt < 64) m_cnt++;
                    m_eta = d + 16384;
                end else begin
                    m_eta = d;
                end
            end
            if (m_state == 0) m_state = 1;
            else if (m_state == 1 && cnt_old == 64) m_state = 2;
        end
        if (wv) m_wlat = (win < 7373) ? 7373 : ((win > 9011) ? 9011 : win);
        e.uk = 16'(m_uk); e.state = 2'(m_state); e.locked = (m_state == 2);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t o;
        rstn = 1'b0;
        bus.enable = 1'b0; bus.sample_valid = 1'b0; bus.w_valid = 1'b0; bus.w_in = 16'sd0;
        model_reset();
        #1;
        o = sample_obs();
        n_vec++;
        if (o !== 22'd0) begin
            n_miscmp++;
            $display("FAIL reset_state got=%h want=%h", o, 22'd0);
        end
        @(posedge clk); #2;
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            o = sample_obs();
            n_vec++;
            if (o !== exp_q.pop_front()) begin
                n_miscmp++;
                $display("FAIL reset_idle cyc=%0d got=%h", i, o);
            end
        end
    endtask

    task automatic test_nominal();
        obs_t o, e;
        strobes_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            o = sample_obs();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_miscmp++;
                $display("FAIL nominal cyc=%0d got=%h want=%h", i, o, e);
            end
            if (o.strobe) begin
                strobes_seen++;
                n_vec++;
                if (o.uk !== 16'd16382) begin
                    n_miscmp++;
                    $display("FAIL nominal_uk got=%0d want=16382", o.uk);
                end
            end
        end
    endtask

    task automatic test_lock();
        obs_t o, e;
        bit pend = 1'b0;
        for (int i = 0; i < 120; i++) begin
            drive(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            o = sample_obs();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_miscmp++;
                $display("FAIL lock cyc=%0d got=%h want=%h", i, o, e);
            end
            if (pend) begin
                n_vec++;
                if (o.locked !== 1'b1 || o.state !== 2'd2) begin
                    n_miscmp++;
                    $display("FAIL lock_edge locked=%b state=%0d want locked=1 state=2", o.locked, o.state);
                end
                pend = 1'b0;
            end
            if (o.strobe) begin
                strobes_seen++;
                if (strobes_seen == 64) pend = 1'b1;
            end
        end
    endtask

    task automatic test_clamp();
        obs_t o, e;
        for (int i = 0; i < 60; i++) begin
            if (i == 0)       drive(1'b1, 1'b0, 1'b1, 20000);
            else if (i == 30) drive(1'b1, 1'b0, 1'b1, -5);
            else              drive(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            o = sample_obs();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_miscmp++;
                $display("FAIL clamp cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_coincide();
        obs_t o, e;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b1, 8192);
            else if (i == 1) drive(1'b1, 1'b1, 1'b1, 7373);
            else             drive(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            o = sample_obs();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_miscmp++;
                $display("FAIL coincide cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        #2;
        rstn = 1'b0;
        #1;
        o = sample_obs();
        n_vec++;
        if (o !== 22'd0) begin
            n_miscmp++;
            $display("FAIL async_reset got=%h want=%h", o, 22'd0);
        end
        model_reset();
        drive(1'b1, 1'b1, 1'b0, 0);
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) drive(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            o = sample_obs();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_miscmp++;
                $display("FAIL async_release cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_enable_drop();
        obs_t o, e;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) drive(1'b0, 1'b1, 1'b0, 0);
            else        drive(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            o = sample_obs();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_miscmp++;
                $display("FAIL enable_drop cyc=%0d got=%h want=%h", i, o, e);
            end
            if (i == 5) begin
                n_vec++;
                if (o.state !== 2'd0 || o.strobe !== 1'b0) begin
                    n_miscmp++;
                    $display("FAIL enable_drop_idle state=%0d strobe=%b want state=0 strobe=0", o.state, o.strobe);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic en, sv, wv;
        int win;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 99) != 0);
            sv  = ($urandom_range(0, 3) != 0);
            wv  = ($urandom_range(0, 7) == 0);
            win = int'($urandom_range(0, 25000)) - 5000;
            drive(en, sv, wv, win);
            @(posedge clk); #1;
            o = sample_obs();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_miscmp++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock();
        test_clamp();
        test_coincide();
        test_async_reset();
        test_enable_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
